// File: rtl/acc_fir_pkg.sv
// Shared types and defaults for the streaming FIR accelerator feeding the DMA result FIFO.
package acc_fir_pkg;

  localparam int DEFAULT_NUM_TAPS   = 11;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_LEN_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_X,
    MAC,
    OUT,
    DONE
  } state_e;

  // Width of a tap index; a single-tap filter still needs a 1-bit counter.
  function automatic int idx_width(input int num_taps);
    return (num_taps > 1) ? $clog2(num_taps) : 1;
  endfunction

endpackage

// File: rtl/acc_fir_engine_if.sv
// Sample input stream and push-only result stream of the FIR engine.
interface acc_fir_engine_if #(
  parameter int DATA_WIDTH = acc_fir_pkg::DEFAULT_DATA_WIDTH
);

  logic                  x_valid_i;
  logic                  x_ready_o;
  logic [DATA_WIDTH-1:0] x_data_i;
  logic                  acc_data_valid_o;
  logic [DATA_WIDTH-1:0] acc_data_o;
  logic                  acc_last_o;

  modport slave (
    input  x_valid_i,
    input  x_data_i,
    output x_ready_o,
    output acc_data_valid_o,
    output acc_data_o,
    output acc_last_o
  );

  modport master (
    output x_valid_i,
    output x_data_i,
    input  x_ready_o,
    input  acc_data_valid_o,
    input  acc_data_o,
    input  acc_last_o
  );

endinterface

// File: rtl/acc_fir_delay_line.sv
// NUM_TAPS-deep sample shift register with synchronous clear and an indexed read port.
module acc_fir_delay_line
  import acc_fir_pkg::*;
#(
  parameter int NUM_TAPS   = DEFAULT_NUM_TAPS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_W      = idx_width(NUM_TAPS)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] taps_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0] taps_d [NUM_TAPS];

  always_comb begin
    // NOTE: default every comb output first; a path that leaves one unassigned infers a latch.
    taps_d = taps_q;
    if (clr_i) begin
      for (int k = 0; k < NUM_TAPS; k++) taps_d[k] = '0;
    end else if (shift_i) begin
      taps_d[0] = din_i;
      for (int k = 1; k < NUM_TAPS; k++) taps_d[k] = taps_q[k-1];
    end
  end

  // NOTE: these are discrete flops, not a RAM macro, so they take a reset like any other state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < NUM_TAPS; k++) taps_q[k] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its neighbours.
      taps_q <= taps_d;
    end
  end

  assign rd_data_o = taps_q[rd_idx_i];

endmodule

// File: rtl/acc_fir_engine.sv
// Streaming FIR accelerator: one shared MAC walks the taps per sample and pushes y[n] to the DMA.
module acc_fir_engine
  import acc_fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_TAPS   = DEFAULT_NUM_TAPS,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             tap_we_i,
  input  logic [idx_width(NUM_TAPS)-1:0]   tap_idx_i,
  input  logic [DATA_WIDTH-1:0]            tap_data_i,
  input  logic [LEN_WIDTH-1:0]             len_i,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic                             done_o,
  acc_fir_engine_if.slave                  s_if
);

  localparam int IDX_W = idx_width(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] coef_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0] coef_d [NUM_TAPS];

  logic                  dl_clr, dl_shift;
  logic [DATA_WIDTH-1:0] dl_rd_data;
  logic                  tap_ok;
  logic                  x_ready, out_valid, out_last, busy, done;

  acc_fir_delay_line #(
    .NUM_TAPS  (NUM_TAPS),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_delay_line (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr_i    (dl_clr),
    .shift_i  (dl_shift),
    .din_i    (s_if.x_data_i),
    .rd_idx_i (cnt_q),
    .rd_data_o(dl_rd_data)
  );

  // The coefficient bank is frozen for the whole run; out-of-range indices are dropped.
  assign tap_ok = tap_we_i && (state_q == IDLE) && (32'(tap_idx_i) < NUM_TAPS);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    coef_d    = coef_q;
    dl_clr    = 1'b0;
    dl_shift  = 1'b0;
    x_ready   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    if (tap_ok) coef_d[tap_idx_i] = tap_data_i;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          dl_clr  = 1'b1;
          acc_d   = '0;
          rem_d   = len_i;
          state_d = (len_i == '0) ? DONE : WAIT_X;
        end
      end
      WAIT_X: begin
        busy    = 1'b1;
        x_ready = 1'b1;
        if (s_if.x_valid_i) begin
          dl_shift = 1'b1;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        busy  = 1'b1;
        // Products and the running sum both wrap modulo 2^DATA_WIDTH.
        acc_d = acc_q + (coef_q[cnt_q] * dl_rd_data);
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_TAP) begin
          result_d = acc_d;
          state_d  = OUT;
        end
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (rem_q == LEN_WIDTH'(1));
        rem_d     = rem_q - LEN_WIDTH'(1);
        state_d   = (rem_q == LEN_WIDTH'(1)) ? DONE : WAIT_X;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      for (int k = 0; k < NUM_TAPS; k++) coef_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      coef_q   <= coef_d;
    end
  end

  assign busy_o                = busy;
  assign done_o                = done;
  assign s_if.x_ready_o        = x_ready;
  assign s_if.acc_data_valid_o = out_valid;
  assign s_if.acc_data_o       = result_q;
  assign s_if.acc_last_o       = out_last;

endmodule

// File: tb/tb_acc_fir_engine.sv
// Directed-vector bench for acc_fir_engine: impulse, step, wrap, empty run, busy guards, reset mid-run.
module tb_acc_fir_engine;
  import acc_fir_pkg::*;

  localparam int NT     = 11;
  localparam int DW     = 32;
  localparam int LW     = 16;
  localparam int IW     = idx_width(NT);
  localparam int BUDGET = 400;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          tap_we_i;
  logic [IW-1:0] tap_idx_i;
  logic [DW-1:0] tap_data_i;
  logic [LW-1:0] len_i;
  logic          start_i;
  logic          busy_o;
  logic          done_o;

  acc_fir_engine_if #(.DATA_WIDTH(DW)) s_if ();

  acc_fir_engine #(
    .DATA_WIDTH(DW),
    .NUM_TAPS  (NT),
    .LEN_WIDTH (LW)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .tap_we_i  (tap_we_i),
    .tap_idx_i (tap_idx_i),
    .tap_data_i(tap_data_i),
    .len_i     (len_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .s_if      (s_if)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] xs[$];
  logic [DW-1:0] res_data[$];
  logic          res_last[$];
  int            res_cyc[$];
  int            done_cnt;
  int            done_cyc;
  int            ready_cnt;

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [DW-1:0] res_at(input int i);
    return (i < res_data.size()) ? res_data[i] : 'x;
  endfunction

  function automatic int last_count();
    int n = 0;
    foreach (res_last[i]) if (res_last[i]) n++;
    return n;
  endfunction

  task automatic write_tap(input int idx, input logic [DW-1:0] data);
    tap_we_i   = 1'b1;
    tap_idx_i  = IW'(idx);
    tap_data_i = data;
    step();
    tap_we_i   = 1'b0;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < NT; k++) write_tap(k, DW'(k + 1));
  endtask

  task automatic set_impulse(input int n);
    xs.delete();
    for (int i = 0; i < n; i++) xs.push_back((i == 0) ? DW'(1) : DW'(0));
  endtask

  // Runs one job from xs; optionally writes tap 0 on the start cycle, and at cycle inj
  // pulses a tap-0 write of 5 plus a start with len 3 (both must be ignored mid-run).
  task automatic run_engine(input int len, input int inj, input bit we_at_start,
                            input logic [DW-1:0] we_data);
    int cyc;
    int xi;
    bit taken;
    res_data.delete();
    res_last.delete();
    res_cyc.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    ready_cnt = 0;
    len_i     = LW'(len);
    start_i   = 1'b1;
    if (we_at_start) begin
      tap_we_i   = 1'b1;
      tap_idx_i  = '0;
      tap_data_i = we_data;
    end
    step();
    start_i  = 1'b0;
    tap_we_i = 1'b0;
    cyc = 1;
    xi  = 0;
    while (cyc < BUDGET) begin
      if (s_if.acc_data_valid_o) begin
        res_data.push_back(s_if.acc_data_o);
        res_last.push_back(s_if.acc_last_o);
        res_cyc.push_back(cyc);
      end
      if (s_if.x_ready_o) ready_cnt++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc > done_cyc) break;
      if (cyc == inj) begin
        tap_we_i   = 1'b1;
        tap_idx_i  = '0;
        tap_data_i = DW'(5);
        start_i    = 1'b1;
        len_i      = LW'(3);
      end else begin
        tap_we_i = 1'b0;
        start_i  = 1'b0;
      end
      s_if.x_valid_i = (xi < xs.size());
      s_if.x_data_i  = (xi < xs.size()) ? xs[xi] : '0;
      taken = s_if.x_ready_o && s_if.x_valid_i;
      step();
      cyc++;
      if (taken) xi++;
    end
    s_if.x_valid_i = 1'b0;
    tap_we_i       = 1'b0;
    start_i        = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL run_done_pulses: got %0d done pulses, want 1 (len=%0d)", done_cnt, len);
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    step();
    step();
    checks++;
    if ({busy_o, done_o, s_if.x_ready_o, s_if.acc_data_valid_o, s_if.acc_last_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/rdy/vld/last=%b, want 00000",
               {busy_o, done_o, s_if.x_ready_o, s_if.acc_data_valid_o, s_if.acc_last_o});
    end
    checks++;
    if (s_if.acc_data_o !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, want 0", s_if.acc_data_o);
    end
    wb_rst_i = 1'b0;
    step();
  endtask

  task automatic test_impulse();
    load_ramp();
    set_impulse(NT);
    run_engine(NT, -1, 1'b0, '0);
    checks++;
    if (res_data.size() != NT) begin
      errors++;
      $display("FAIL impulse_count: got %0d results, want %0d", res_data.size(), NT);
    end
    for (int i = 0; i < NT; i++) begin
      checks++;
      if (res_at(i) !== DW'(i + 1)) begin
        errors++;
        $display("FAIL impulse_y%0d: got %h, want %h", i, res_at(i), DW'(i + 1));
      end
    end
    checks++;
    if (res_cyc.size() == 0 || res_cyc[0] != NT + 2) begin
      errors++;
      $display("FAIL impulse_latency: first result cycle %0d, want %0d",
               (res_cyc.size() != 0) ? res_cyc[0] : -1, NT + 2);
    end
    checks++;
    if (last_count() != 1 || res_last.size() != NT || res_last[NT-1] !== 1'b1) begin
      errors++;
      $display("FAIL impulse_last: got %0d last flags, want exactly 1 on result %0d", last_count(), NT);
    end
    checks++;
    if (res_cyc.size() != NT || done_cyc != res_cyc[NT-1] + 1) begin
      errors++;
      $display("FAIL impulse_done_timing: done at cycle %0d, want one after last result", done_cyc);
    end
  endtask

  task automatic test_step();
    logic [DW-1:0] exp_y [12] = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 66, 66};
    xs.delete();
    for (int i = 0; i < 12; i++) xs.push_back(DW'(1));
    run_engine(12, -1, 1'b0, '0);
    checks++;
    if (res_data.size() != 12) begin
      errors++;
      $display("FAIL step_count: got %0d results, want 12", res_data.size());
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (res_at(i) !== exp_y[i]) begin
        errors++;
        $display("FAIL step_y%0d: got %0d, want %0d", i, res_at(i), exp_y[i]);
      end
    end
    for (int i = 1; i < res_cyc.size(); i++) begin
      checks++;
      if (res_cyc[i] - res_cyc[i-1] != NT + 2) begin
        errors++;
        $display("FAIL step_spacing%0d: got %0d cycles, want %0d", i, res_cyc[i] - res_cyc[i-1], NT + 2);
      end
    end
  endtask

  task automatic test_wrap();
    write_tap(0, 32'hFFFF_FFFF);
    for (int k = 1; k < NT; k++) write_tap(k, '0);
    xs.delete();
    xs.push_back(DW'(2));
    run_engine(1, -1, 1'b0, '0);
    checks++;
    if (res_data.size() != 1 || res_at(0) !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL wrap_value: got %h (%0d results), want fffffffe (1 result)", res_at(0), res_data.size());
    end
    checks++;
    if (res_last.size() != 1 || res_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_last: got %0d last flags, want 1", last_count());
    end
  endtask

  task automatic test_len_zero();
    xs.delete();
    run_engine(0, -1, 1'b0, '0);
    checks++;
    if (done_cyc < 1 || done_cyc > 2) begin
      errors++;
      $display("FAIL len0_done_timing: done at cycle %0d after start, want 1..2", done_cyc);
    end
    checks++;
    if (res_data.size() != 0) begin
      errors++;
      $display("FAIL len0_no_output: got %0d results, want 0", res_data.size());
    end
    checks++;
    if (ready_cnt != 0) begin
      errors++;
      $display("FAIL len0_no_ready: x_ready_o seen %0d cycles, want 0", ready_cnt);
    end
  endtask

  task automatic test_busy_guards();
    load_ramp();
    set_impulse(NT);
    run_engine(NT, 5, 1'b0, '0);
    checks++;
    if (res_data.size() != NT) begin
      errors++;
      $display("FAIL guard_len: got %0d results, want %0d", res_data.size(), NT);
    end
    for (int i = 0; i < NT; i++) begin
      checks++;
      if (res_at(i) !== DW'(i + 1)) begin
        errors++;
        $display("FAIL guard_y%0d: got %h, want %h", i, res_at(i), DW'(i + 1));
      end
    end
    // The same write issued in IDLE does land; out-of-range indices must not disturb anything.
    write_tap(0, DW'(5));
    write_tap(NT, DW'(99));
    write_tap((1 << IW) - 1, DW'(99));
    set_impulse(NT);
    run_engine(NT, -1, 1'b0, '0);
    checks++;
    if (res_at(0) !== DW'(5) || res_at(1) !== DW'(2) || res_at(NT-1) !== DW'(NT)) begin
      errors++;
      $display("FAIL guard_idle_write: got y0=%0d y1=%0d y10=%0d, want 5 2 %0d",
               res_at(0), res_at(1), res_at(NT-1), NT);
    end
    set_impulse(2);
    run_engine(2, -1, 1'b1, DW'(7));
    checks++;
    if (res_data.size() != 2 || res_at(0) !== DW'(7) || res_at(1) !== DW'(2)) begin
      errors++;
      $display("FAIL guard_write_with_start: got y0=%0d y1=%0d (%0d results), want 7 2 (2 results)",
               res_at(0), res_at(1), res_data.size());
    end
  endtask

  task automatic test_reset_mid_run();
    load_ramp();
    len_i   = LW'(NT);
    start_i = 1'b1;
    step();
    start_i        = 1'b0;
    s_if.x_valid_i = 1'b1;
    s_if.x_data_i  = DW'(1);
    step();
    s_if.x_valid_i = 1'b0;
    s_if.x_data_i  = '0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (busy_o !== 1'b1 || s_if.x_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midrun_in_mac: busy=%b rdy=%b, want busy=1 rdy=0", busy_o, s_if.x_ready_o);
    end
    wb_rst_i = 1'b1;
    step();
    checks++;
    if ({busy_o, done_o, s_if.x_ready_o, s_if.acc_data_valid_o, s_if.acc_last_o} !== 5'b0
        || s_if.acc_data_o !== '0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got flags=%b data=%h, want 00000 and 0",
               {busy_o, done_o, s_if.x_ready_o, s_if.acc_data_valid_o, s_if.acc_last_o}, s_if.acc_data_o);
    end
    wb_rst_i = 1'b0;
    step();
    set_impulse(NT);
    run_engine(NT, -1, 1'b0, '0);
    checks++;
    if (res_data.size() != NT || res_at(0) !== '0 || res_at(NT-1) !== '0) begin
      errors++;
      $display("FAIL midrun_coef_cleared: got y0=%h y10=%h (%0d results), want 0 0 (%0d results)",
               res_at(0), res_at(NT-1), res_data.size(), NT);
    end
    load_ramp();
    set_impulse(NT);
    run_engine(NT, -1, 1'b0, '0);
    for (int i = 0; i < NT; i++) begin
      checks++;
      if (res_at(i) !== DW'(i + 1)) begin
        errors++;
        $display("FAIL midrun_rerun_y%0d: got %h, want %h", i, res_at(i), DW'(i + 1));
      end
    end
  endtask

  initial begin
    wb_rst_i       = 1'b1;
    tap_we_i       = 1'b0;
    tap_idx_i      = '0;
    tap_data_i     = '0;
    len_i          = '0;
    start_i        = 1'b0;
    s_if.x_valid_i = 1'b0;
    s_if.x_data_i  = '0;
    test_reset();
    test_impulse();
    test_step();
    test_wrap();
    test_len_zero();
    test_busy_guards();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
